// File: rtl/alu_seq.sv
// alu_seq: start/busy/done ALU stage fed by the operand-entry logic.
//   Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, DIV by zero) complete on the
//   start edge. MUL and DIV run 16 shift-add / restoring-subtract iterations.
//   The result and flags are registered and held until the next completion.
// Ports:
//   hz100   in   system clock (rising edge)
//   reset   in   asynchronous active-high reset
//   a, b    in   operands, sampled only on an accepted start
//   op      in   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 MUL, 7 DIV
//   start   in   request pulse, honoured only while idle
//   busy    out  high while not idle
//   done    out  one-cycle completion pulse
//   result  out  registered result
//   flag_z/n/c/v/dz out  zero, negative, carry/borrow/mul-overflow,
//                        signed overflow, divide-by-zero
module alu_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             hz100,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_dz
);

   localparam int unsigned CntW = $clog2(WIDTH);

   localparam logic [2:0] OpAdd = 3'd0;
   localparam logic [2:0] OpSub = 3'd1;
   localparam logic [2:0] OpAnd = 3'd2;
   localparam logic [2:0] OpOr  = 3'd3;
   localparam logic [2:0] OpXor = 3'd4;
   localparam logic [2:0] OpShl = 3'd5;
   localparam logic [2:0] OpMul = 3'd6;
   localparam logic [2:0] OpDiv = 3'd7;

   typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [2:0]        op_q;
   logic [WIDTH-1:0]  b_q;
   // MUL: {hi_q, lo_q} is partial product / remaining multiplier.
   // DIV: hi_q is the partial remainder, lo_q shifts dividend out and quotient in.
   logic [WIDTH-1:0]  hi_q, lo_q;
   logic [WIDTH-1:0]  hi_d, lo_d;

   // Single-cycle datapath, evaluated straight from the inputs at the start edge.
   logic [WIDTH:0]    add_sum, sub_diff;
   logic [WIDTH-1:0]  sc_res;
   logic              sc_c, sc_v, sc_dz;
   logic              iterative;

   assign add_sum   = {1'b0, a} + {1'b0, b};
   assign sub_diff  = {1'b0, a} - {1'b0, b};  // MSB is the borrow
   assign iterative = (op == OpMul) || ((op == OpDiv) && (b != '0));

   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_dz  = 1'b0;
      case (op)
         OpAdd: begin
            sc_res = add_sum[WIDTH-1:0];
            sc_c   = add_sum[WIDTH];
            sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OpSub: begin
            sc_res = sub_diff[WIDTH-1:0];
            sc_c   = sub_diff[WIDTH];
            sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OpAnd: sc_res = a & b;
         OpOr:  sc_res = a | b;
         OpXor: sc_res = a ^ b;
         OpShl: sc_res = a << b[CntW-1:0];
         // Only DIV by zero completes in one cycle.
         OpDiv: begin
            sc_res = '1;
            sc_dz  = 1'b1;
         end
         default: sc_res = '0;  // MUL never completes here
      endcase
   end

   // One iteration step of MUL or DIV.
   logic [WIDTH:0] mul_sum, div_shift, div_diff;
   logic           div_ge, fin_c;

   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
   assign div_shift = {hi_q, lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, b_q};
   assign div_ge    = div_shift >= {1'b0, b_q};

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (op_q == OpMul) begin
         hi_d = mul_sum[WIDTH:1];
         lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else if (div_ge) begin
         hi_d = div_diff[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         hi_d = div_shift[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
   end

   // MUL overflow: any bit set in the upper half of the final product.
   assign fin_c = (op_q == OpMul) && (hi_d != '0);

   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= OpAdd;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         flag_z  <= 1'b0;
         flag_n  <= 1'b0;
         flag_c  <= 1'b0;
         flag_v  <= 1'b0;
         flag_dz <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  op_q  <= op;
                  b_q   <= b;
                  hi_q  <= '0;
                  lo_q  <= a;
                  cnt_q <= '0;
                  busy  <= 1'b1;
                  if (iterative) begin
                     state_q <= StIter;
                  end else begin
                     result  <= sc_res;
                     flag_z  <= (sc_res == '0);
                     flag_n  <= sc_res[WIDTH-1];
                     flag_c  <= sc_c;
                     flag_v  <= sc_v;
                     flag_dz <= sc_dz;
                     done    <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StIter: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  result  <= lo_d;
                  flag_z  <= (lo_d == '0);
                  flag_n  <= lo_d[WIDTH-1];
                  flag_c  <= fin_c;
                  flag_v  <= 1'b0;
                  flag_dz <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed cases followed by randomized operations,
// each checked against an arithmetic reference model.
module tb_alu_seq;

   logic        hz100;
   logic        reset;
   logic [15:0] a, b;
   logic [2:0]  op;
   logic        start;
   logic        busy, done;
   logic [15:0] result;
   logic        flag_z, flag_n, flag_c, flag_v, flag_dz;

   int n_checks = 0;
   int n_errors = 0;

   alu_seq #(.WIDTH(16)) u_dut (
      .hz100   (hz100),
      .reset   (reset),
      .a       (a),
      .b       (b),
      .op      (op),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .flag_z  (flag_z),
      .flag_n  (flag_n),
      .flag_c  (flag_c),
      .flag_v  (flag_v),
      .flag_dz (flag_dz)
   );

   initial hz100 = 1'b0;
   always #5 hz100 = ~hz100;

   typedef struct packed {
      logic [15:0] r;
      logic        z, n, c, v, dz;
      int          lat;
   } exp_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain arithmetic on the operation definitions.
   function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      exp_t        e;
      int unsigned full;
      logic [31:0] p;
      e     = '0;
      e.lat = 0;
      case (o)
         3'd0: begin
            full = int'(x) + int'(y);
            e.r  = full[15:0];
            e.c  = full[16];
            e.v  = (x[15] == y[15]) && (e.r[15] != x[15]);
         end
         3'd1: begin
            e.r = x - y;
            e.c = x < y;
            e.v = (x[15] != y[15]) && (e.r[15] != x[15]);
         end
         3'd2: e.r = x & y;
         3'd3: e.r = x | y;
         3'd4: e.r = x ^ y;
         3'd5: e.r = x << y[3:0];
         3'd6: begin
            p     = 32'(x) * 32'(y);
            e.r   = p[15:0];
            e.c   = p[31:16] != 16'h0;
            e.lat = 16;
         end
         default: begin
            if (y == 16'h0) begin
               e.r  = 16'hFFFF;
               e.dz = 1'b1;
            end else begin
               e.r   = x / y;
               e.lat = 16;
            end
         end
      endcase
      e.z = (e.r == 16'h0);
      e.n = e.r[15];
      return e;
   endfunction

   // Issue one operation; optionally inject an ignored start at step 'disturb'.
   task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         input int disturb);
      exp_t e;
      int   lat;
      int   busy_gaps;
      e         = model(o, x, y);
      busy_gaps = 0;
      @(negedge hz100);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge hz100);
      #1 start = 1'b0;
      lat = -1;
      do begin
         @(negedge hz100);
         lat++;
         if (!busy) busy_gaps++;
         if (lat == disturb && !done) begin
            op    = 3'd0;
            a     = ~x;
            b     = 16'h1111;
            start = 1'b1;
            @(posedge hz100);
            #1 start = 1'b0;
         end
      end while (!done && lat < 40);
      check($sformatf("latency op%0d", o), 32'(lat), 32'(e.lat));
      check($sformatf("busy op%0d", o), 32'(busy_gaps), 32'd0);
      check($sformatf("result op%0d %h,%h", o, x, y), {16'h0, result}, {16'h0, e.r});
      check($sformatf("flags op%0d %h,%h", o, x, y),
            {27'h0, flag_z, flag_n, flag_c, flag_v, flag_dz},
            {27'h0, e.z, e.n, e.c, e.v, e.dz});
      @(negedge hz100);
      check("idle after done", {30'h0, busy, done}, 32'd0);
   endtask

   initial begin
      int dones;
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      op    = '0;
      repeat (2) @(posedge hz100);
      #1 reset = 1'b0;
      @(negedge hz100);
      check("reset outputs",
            {9'h0, busy, done, result, flag_z, flag_n, flag_c, flag_v, flag_dz}, 32'd0);

      run_op(3'd0, 16'h7FFF, 16'h0001, -2);
      run_op(3'd1, 16'h0003, 16'h0005, -2);
      run_op(3'd1, 16'h1234, 16'h1234, -2);
      run_op(3'd6, 16'h0100, 16'h0100, -2);
      run_op(3'd6, 16'h00FF, 16'h0101, -2);
      run_op(3'd7, 16'd1000, 16'd7, -2);
      run_op(3'd7, 16'h1234, 16'h0000, -2);
      run_op(3'd0, 16'h0001, 16'h0002, -2);
      run_op(3'd6, 16'h1234, 16'h0567, 5);
      run_op(3'd5, 16'h0001, 16'h001F, -2);
      run_op(3'd4, 16'hAAAA, 16'hFFFF, -2);
      run_op(3'd7, 16'hFFFF, 16'h0001, -2);
      run_op(3'd7, 16'h0005, 16'hFFFF, -2);

      // Reset in the middle of a DIV: outputs clear at once, no done pulse.
      @(negedge hz100);
      op    = 3'd7;
      a     = 16'd5000;
      b     = 16'd3;
      start = 1'b1;
      @(posedge hz100);
      #1 start = 1'b0;
      repeat (8) @(negedge hz100);
      reset = 1'b1;
      #1;
      check("async reset mid-div",
            {9'h0, busy, done, result, flag_z, flag_n, flag_c, flag_v, flag_dz}, 32'd0);
      @(posedge hz100);
      #1 reset = 1'b0;
      dones = 0;
      repeat (24) begin
         @(negedge hz100);
         if (done || busy) dones++;
      end
      check("no done after abort", 32'(dones), 32'd0);

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  ro;
         logic [15:0] ra, rb;
         ro = 3'($urandom_range(0, 7));
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (ro == 3'd7 && $urandom_range(0, 3) == 0) rb = 16'h0;
         run_op(ro, ra, rb, (i % 5 == 0) ? 3 : -2);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
